// File: rtl/sync_out_gen.sv
// Avalon-MM sync output generator: periodic/one-shot pulses or a static level on out_port.
// Optional macro SYNC_OUT_IRQ_EN enables CONTROL.IRQ_EN and the irq output.
module sync_out_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        out_port
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [31:0] cnt_r, cnt_s;
  logic [31:0] pe_r, pe_s;
  logic [31:0] we_r, we_s;
  logic [31:0] period_r, period_s;
  logic [31:0] width_r, width_s;
  logic        level_r, level_s;
  logic        run_r, run_s;
  logic        oneshot_r, oneshot_s;
  logic        irq_en_r, irq_en_s;
  logic        done_r, done_s;
  logic [15:0] pcount_r, pcount_s;
  logic        out_r, out_s;
  logic        irq_r, irq_s;
  logic [31:0] readdata_r, readdata_s;

  logic        wr_s, wr_ctrl_s, wr_stat_s, start_s, period_end_s;
  logic [31:0] pe_calc_s, we_calc_s;

  // Next-state logic for the bus registers, FSM, counters and registered outputs
  always_comb begin
    wr_s      = chipselect & ~write_n;
    wr_ctrl_s = wr_s & (address == 2'd0);
    wr_stat_s = wr_s & (address == 2'd3);
    start_s   = wr_ctrl_s & (writedata[1] | writedata[2]);
    pe_calc_s = (period_r < 32'd2) ? 32'd2 : period_r;
    we_calc_s = (width_r < pe_calc_s) ? width_r : (pe_calc_s - 32'd1);
    period_end_s = (state_r == ST_ACTIVE) && (cnt_r == (pe_r - 32'd1));

    period_s = (wr_s && (address == 2'd1)) ? writedata : period_r;
    width_s  = (wr_s && (address == 2'd2)) ? writedata : width_r;
    level_s   = wr_ctrl_s ? writedata[0] : level_r;
    run_s     = wr_ctrl_s ? writedata[1] : run_r;
    oneshot_s = wr_ctrl_s ? writedata[2] : oneshot_r;
`ifdef SYNC_OUT_IRQ_EN
    irq_en_s  = wr_ctrl_s ? writedata[3] : irq_en_r;
`else
    irq_en_s  = 1'b0;
`endif

    state_s  = state_r;
    cnt_s    = cnt_r;
    pe_s     = pe_r;
    we_s     = we_r;
    done_s   = done_r;
    pcount_s = pcount_r;

    case (state_r)
      ST_IDLE: begin
        cnt_s = 32'd0;
        if (start_s) begin
          state_s = ST_ACTIVE;
          pe_s    = pe_calc_s;
          we_s    = we_calc_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (wr_ctrl_s && !start_s) begin
          // Abort: no period completion is recorded
          state_s = ST_IDLE;
          cnt_s   = 32'd0;
        end else if (period_end_s) begin
          done_s   = 1'b1;
          pcount_s = pcount_r + 16'd1;
          cnt_s    = 32'd0;
          if (run_s) begin
            pe_s      = pe_calc_s;
            we_s      = we_calc_s;
            oneshot_s = wr_ctrl_s ? writedata[2] : 1'b0;
          end else begin
            state_s   = ST_IDLE;
            oneshot_s = 1'b0;
          end
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 32'd0;
      end
    endcase

    // A STATUS write wins over a coinciding period end
    if (wr_stat_s) begin
      done_s   = 1'b0;
      pcount_s = 16'd0;
    end else begin
      done_s   = done_s;
      pcount_s = pcount_s;
    end

    out_s = (state_s == ST_ACTIVE) ? (cnt_s < we_s) : level_s;
`ifdef SYNC_OUT_IRQ_EN
    irq_s = irq_en_s & done_s;
`else
    irq_s = 1'b0;
`endif

    case (address)
      2'd0:    readdata_s = {28'd0, irq_en_r, oneshot_r, run_r, level_r};
      2'd1:    readdata_s = period_r;
      2'd2:    readdata_s = width_r;
      2'd3:    readdata_s = {pcount_r, 14'd0, done_r, (state_r == ST_ACTIVE)};
      default: readdata_s = 32'd0;
    endcase
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 32'd0;
      pe_r       <= 32'd0;
      we_r       <= 32'd0;
      period_r   <= 32'd0;
      width_r    <= 32'd0;
      level_r    <= 1'b0;
      run_r      <= 1'b0;
      oneshot_r  <= 1'b0;
      irq_en_r   <= 1'b0;
      done_r     <= 1'b0;
      pcount_r   <= 16'd0;
      out_r      <= 1'b0;
      irq_r      <= 1'b0;
      readdata_r <= 32'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      pe_r       <= pe_s;
      we_r       <= we_s;
      period_r   <= period_s;
      width_r    <= width_s;
      level_r    <= level_s;
      run_r      <= run_s;
      oneshot_r  <= oneshot_s;
      irq_en_r   <= irq_en_s;
      done_r     <= done_s;
      pcount_r   <= pcount_s;
      out_r      <= out_s;
      irq_r      <= irq_s;
      readdata_r <= readdata_s;
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;
  assign out_port = out_r;

endmodule

// File: tb/tb_sync_out_gen.sv
// Directed-vector bench for sync_out_gen; expected values are hand-computed.
module tb_sync_out_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        out_port;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] rd;

`ifdef SYNC_OUT_IRQ_EN
  localparam logic [31:0] IRQ_EXP  = 32'd1;
  localparam logic [31:0] CTRL_EXP = 32'h8;
`else
  localparam logic [31:0] IRQ_EXP  = 32'd0;
  localparam logic [31:0] CTRL_EXP = 32'h0;
`endif

  sync_out_gen dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (cyc %0d): got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task tick;
    @(negedge clk);
    cyc++;
  endtask

  task bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
    d          = readdata;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check_val("rst_out", {31'd0, out_port}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], rd);
      check_val("rst_read", rd, 32'd0);
    end

    // Static level
    bus_write(2'd0, 32'h1);
    check_val("level_hi", {31'd0, out_port}, 32'd1);
    bus_write(2'd0, 32'h0);
    check_val("level_lo", {31'd0, out_port}, 32'd0);

    // Continuous P=10 W=3
    bus_write(2'd1, 32'd10);
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'h2);
    cyc = 0;
    while (cyc < 52) begin
      check_val("run_out", {31'd0, out_port}, ((cyc % 10) < 3) ? 32'd1 : 32'd0);
      tick();
    end
    bus_read(2'd3, rd);
    check_val("run_status5", rd, 32'h0005_0003);

    // WIDTH change at cnt=1 applies from the next period
    while (cyc < 61) tick();
    bus_write(2'd2, 32'd6);
    while (cyc < 90) begin
      check_val("midw_out", {31'd0, out_port},
                ((cyc % 10) < ((cyc >= 70) ? 6 : 3)) ? 32'd1 : 32'd0);
      tick();
    end

    // Abort at cnt=5
    while (cyc < 95) tick();
    bus_write(2'd0, 32'h0);
    while (cyc < 104) begin
      check_val("abort_out", {31'd0, out_port}, 32'd0);
      tick();
    end
    bus_read(2'd3, rd);
    check_val("abort_status", rd, 32'h0009_0002);

    // One-shot with IRQ_EN
    bus_write(2'd3, 32'd0);
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'hC);
    cyc = 0;
    check_val("os_out0", {31'd0, out_port}, 32'd1);
    check_val("os_irq0", {31'd0, irq}, 32'd0);
    tick();
    check_val("os_out1", {31'd0, out_port}, 32'd0);
    tick();
    tick();
    check_val("os_out3", {31'd0, out_port}, 32'd0);
    check_val("os_irq3", {31'd0, irq}, 32'd0);
    tick();
    check_val("os_out4", {31'd0, out_port}, 32'd0);
    check_val("os_irq4", {31'd0, irq}, IRQ_EXP);
    bus_read(2'd0, rd);
    check_val("os_ctrl", rd, CTRL_EXP);
    bus_read(2'd3, rd);
    check_val("os_status", rd, 32'h0001_0002);
    bus_write(2'd3, 32'd0);
    check_val("os_irq_clr", {31'd0, irq}, 32'd0);
    bus_read(2'd3, rd);
    check_val("os_status_clr", rd, 32'd0);

    // Clamping: PERIOD=1 WIDTH=5 -> Pe=2 We=1
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd5);
    bus_write(2'd0, 32'h2);
    cyc = 0;
    while (cyc < 8) begin
      check_val("clamp_out", {31'd0, out_port}, ((cyc % 2) == 0) ? 32'd1 : 32'd0);
      tick();
    end
    bus_write(2'd0, 32'h0);
    check_val("clamp_stop", {31'd0, out_port}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
